// File: rtl/issue_queue_mi.sv
// rtl/issue_queue_mi.sv - multi-issue, age-ordered issue queue with tag wakeup, sqN squash and per-port backpressure
// Optional feature macro: IQ_DELAYED_WAKE_EN (delayed wakeup bus for multi-cycle producers)
module issue_queue_mi #(
    parameter int SIZE         = 16,
    parameter int NUM_OPERANDS = 2,
    parameter int NUM_ENQ      = 4,
    parameter int NUM_ISSUE    = 2,
    parameter int NUM_WAKE     = 4,
    parameter int TAG_W        = 7,
    parameter int SQN_W        = 7,
    parameter int PAYLOAD_W    = 64
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_ENQ-1:0]                       IN_enqValid,
    input  logic [NUM_ENQ*NUM_OPERANDS*TAG_W-1:0]    IN_enqTags,
    input  logic [NUM_ENQ*NUM_OPERANDS-1:0]          IN_enqAvail,
    input  logic [NUM_ENQ*SQN_W-1:0]                 IN_enqSqN,
    input  logic [NUM_ENQ*PAYLOAD_W-1:0]             IN_enqPayload,
    input  logic [NUM_WAKE-1:0]                      IN_wakeValid,
    input  logic [NUM_WAKE*TAG_W-1:0]                IN_wakeTag,
`ifdef IQ_DELAYED_WAKE_EN
    input  logic [NUM_WAKE-1:0]                      IN_dlyWakeValid,
    input  logic [NUM_WAKE*TAG_W-1:0]                IN_dlyWakeTag,
`endif
    input  logic                                     IN_flushValid,
    input  logic [SQN_W-1:0]                         IN_flushSqN,
    input  logic [NUM_ISSUE-1:0]                     IN_issueReady,
    output logic [NUM_ISSUE-1:0]                     OUT_issueValid,
    output logic [NUM_ISSUE*NUM_OPERANDS*TAG_W-1:0]  OUT_issueTags,
    output logic [NUM_ISSUE*SQN_W-1:0]               OUT_issueSqN,
    output logic [NUM_ISSUE*PAYLOAD_W-1:0]           OUT_issuePayload,
    output logic [$clog2(SIZE):0]                    OUT_free,
    output logic                                     OUT_full
);
    localparam int IW = $clog2(SIZE);
    localparam int CW = IW + 1;

    function automatic logic f_match(input logic [TAG_W-1:0] tag, input logic [NUM_WAKE-1:0] vld,
                                     input logic [NUM_WAKE*TAG_W-1:0] bus);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < NUM_WAKE; j++)
            if (vld[j] && bus[j*TAG_W +: TAG_W] == tag) hit = 1'b1;
        return hit;
    endfunction

    // Wrap-safe age compare: strictly younger means a positive signed difference.
    function automatic logic f_younger(input logic [SQN_W-1:0] sqn, input logic [SQN_W-1:0] flush_sqn);
        logic [SQN_W-1:0] diff;
        diff = sqn - flush_sqn;
        return !diff[SQN_W-1] && (diff != '0);
    endfunction

    logic [TAG_W-1:0]        r_tags    [SIZE][NUM_OPERANDS];
    logic [NUM_OPERANDS-1:0] r_avail   [SIZE];
    logic [SQN_W-1:0]        r_sqn     [SIZE];
    logic [PAYLOAD_W-1:0]    r_payload [SIZE];
    logic [CW-1:0]           r_count;
    logic [CW-1:0]           r_free;
    logic                    r_full;

    logic [TAG_W-1:0]        w_n_tags    [SIZE][NUM_OPERANDS];
    logic [NUM_OPERANDS-1:0] w_n_avail   [SIZE];
    logic [SQN_W-1:0]        w_n_sqn     [SIZE];
    logic [PAYLOAD_W-1:0]    w_n_payload [SIZE];
    logic [CW-1:0]           w_n_count;
    logic                    w_accept;
`ifdef IQ_DELAYED_WAKE_EN
    logic [NUM_OPERANDS-1:0] r_pend   [SIZE];
    logic [NUM_OPERANDS-1:0] w_n_pend [SIZE];
`endif

    logic [NUM_ISSUE-1:0]    r_iss_valid;
    logic [TAG_W-1:0]        r_iss_tags    [NUM_ISSUE][NUM_OPERANDS];
    logic [SQN_W-1:0]        r_iss_sqn     [NUM_ISSUE];
    logic [PAYLOAD_W-1:0]    r_iss_payload [NUM_ISSUE];

    logic [NUM_OPERANDS-1:0] w_wake_hit [SIZE];
    logic [SIZE-1:0]         w_ready;
    logic [SIZE-1:0]         w_taken;
    logic [NUM_ISSUE-1:0]    w_can_load;
    logic [NUM_ISSUE-1:0]    w_port_hit;
    logic [IW-1:0]           w_port_entry [NUM_ISSUE];

    always_comb begin
        for (int e = 0; e < SIZE; e++) begin
            for (int k = 0; k < NUM_OPERANDS; k++)
                w_wake_hit[e][k] = f_match(r_tags[e][k], IN_wakeValid, IN_wakeTag);
            w_ready[e] = (CW'(e) < r_count) && (&(r_avail[e] | w_wake_hit[e]));
        end
    end

    // i-th oldest ready entry goes to the i-th loadable port.
    always_comb begin
        logic [SIZE-1:0] taken;
        taken = '0;
        for (int p = 0; p < NUM_ISSUE; p++) begin
            w_can_load[p]   = !r_iss_valid[p] || IN_issueReady[p];
            w_port_hit[p]   = 1'b0;
            w_port_entry[p] = '0;
            if (w_can_load[p] && !IN_flushValid) begin
                for (int e = 0; e < SIZE; e++) begin
                    if (w_ready[e] && !taken[e] && !w_port_hit[p]) begin
                        w_port_hit[p]   = 1'b1;
                        w_port_entry[p] = IW'(e);
                        taken[e]        = 1'b1;
                    end
                end
            end
        end
        w_taken = taken;
    end

    // Survivors compact towards entry 0, then accepted uops append in port order.
    always_comb begin
        logic [CW-1:0] pos;
        logic [CW-1:0] enq_n;
        w_n_tags    = r_tags;
        w_n_avail   = r_avail;
        w_n_sqn     = r_sqn;
        w_n_payload = r_payload;
`ifdef IQ_DELAYED_WAKE_EN
        w_n_pend    = r_pend;
`endif
        pos = '0;
        for (int e = 0; e < SIZE; e++) begin
            if ((CW'(e) < r_count) && !w_taken[e] &&
                !(IN_flushValid && f_younger(r_sqn[e], IN_flushSqN))) begin
                w_n_tags[pos[IW-1:0]]    = r_tags[e];
                w_n_avail[pos[IW-1:0]]   = r_avail[e] | w_wake_hit[e];
                w_n_sqn[pos[IW-1:0]]     = r_sqn[e];
                w_n_payload[pos[IW-1:0]] = r_payload[e];
`ifdef IQ_DELAYED_WAKE_EN
                w_n_avail[pos[IW-1:0]] = w_n_avail[pos[IW-1:0]] | r_pend[e];
                for (int k = 0; k < NUM_OPERANDS; k++)
                    w_n_pend[pos[IW-1:0]][k] = r_pend[e][k] |
                        f_match(r_tags[e][k], IN_dlyWakeValid, IN_dlyWakeTag);
`endif
                pos = pos + CW'(1);
            end
        end
        enq_n = '0;
        for (int q = 0; q < NUM_ENQ; q++)
            enq_n = enq_n + CW'(IN_enqValid[q]);
        // Room is judged on the pre-issue count so acceptance never depends on select.
        w_accept = !IN_flushValid && (enq_n <= CW'(SIZE) - r_count);
        if (w_accept) begin
            for (int q = 0; q < NUM_ENQ; q++) begin
                if (IN_enqValid[q] && pos < CW'(SIZE)) begin
                    for (int k = 0; k < NUM_OPERANDS; k++) begin
                        w_n_tags[pos[IW-1:0]][k]  = IN_enqTags[(q*NUM_OPERANDS+k)*TAG_W +: TAG_W];
                        w_n_avail[pos[IW-1:0]][k] = IN_enqAvail[q*NUM_OPERANDS+k] |
                            f_match(IN_enqTags[(q*NUM_OPERANDS+k)*TAG_W +: TAG_W], IN_wakeValid, IN_wakeTag);
`ifdef IQ_DELAYED_WAKE_EN
                        w_n_pend[pos[IW-1:0]][k]  =
                            f_match(IN_enqTags[(q*NUM_OPERANDS+k)*TAG_W +: TAG_W], IN_dlyWakeValid, IN_dlyWakeTag);
`endif
                    end
                    w_n_sqn[pos[IW-1:0]]     = IN_enqSqN[q*SQN_W +: SQN_W];
                    w_n_payload[pos[IW-1:0]] = IN_enqPayload[q*PAYLOAD_W +: PAYLOAD_W];
                    pos = pos + CW'(1);
                end
            end
        end
        w_n_count = pos;
    end

    always_ff @(posedge clk) begin
        r_tags    <= w_n_tags;
        r_avail   <= w_n_avail;
        r_sqn     <= w_n_sqn;
        r_payload <= w_n_payload;
`ifdef IQ_DELAYED_WAKE_EN
        r_pend    <= w_n_pend;
`endif
        for (int p = 0; p < NUM_ISSUE; p++) begin
            if (!IN_flushValid && w_can_load[p] && w_port_hit[p]) begin
                r_iss_tags[p]    <= r_tags[w_port_entry[p]];
                r_iss_sqn[p]     <= r_sqn[w_port_entry[p]];
                r_iss_payload[p] <= r_payload[w_port_entry[p]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count     <= '0;
            r_iss_valid <= '0;
            r_free      <= CW'(SIZE);
            r_full      <= 1'b0;
        end else begin
            r_count <= w_n_count;
            r_free  <= CW'(SIZE) - w_n_count;
            r_full  <= (CW'(SIZE) - w_n_count) < CW'(NUM_ENQ);
            for (int p = 0; p < NUM_ISSUE; p++) begin
                if (IN_flushValid) begin
                    if (r_iss_valid[p] && f_younger(r_iss_sqn[p], IN_flushSqN))
                        r_iss_valid[p] <= 1'b0;
                end else if (w_can_load[p]) begin
                    r_iss_valid[p] <= w_port_hit[p];
                end
            end
        end
    end

    always_comb begin
        OUT_issueTags    = '0;
        OUT_issueSqN     = '0;
        OUT_issuePayload = '0;
        for (int p = 0; p < NUM_ISSUE; p++) begin
            for (int k = 0; k < NUM_OPERANDS; k++)
                OUT_issueTags[(p*NUM_OPERANDS+k)*TAG_W +: TAG_W] = r_iss_tags[p][k];
            OUT_issueSqN[p*SQN_W +: SQN_W]             = r_iss_sqn[p];
            OUT_issuePayload[p*PAYLOAD_W +: PAYLOAD_W] = r_iss_payload[p];
        end
    end

    assign OUT_issueValid = r_iss_valid;
    assign OUT_free       = r_free;
    assign OUT_full       = r_full;

endmodule
